// File: rtl/gcd_wb_ctrl.sv
// ---------------------------------------------------------------------------
// gcd_wb_ctrl
//
// Wishbone-slave controller for the GCD datapath. The management SoC writes
// operand pairs into CMD. The controller issues each pair to the GCD unit over
// a val/rdy request port and collects the result over a val/rdy response
// port. Results are buffered in a small FIFO that software pops through
// RESULT. The latency of each operation is recorded in CYCLES, and a level
// interrupt is raised while results are pending or an overflow is flagged.
//
// Register map (index = wbs_adr_i[4:2], 32-byte window at BASE_ADDR):
//   0 CMD    (W)   A = dat[W-1:0], B = dat[16+W-1:16]; dropped (OVF set) if busy
//   1 RESULT (R)   FIFO head, zero-extended; pops. Reads 0 and does not pop if empty
//   2 STATUS (R)   [0] busy [1] nonempty [2] full [3] OVF [7:4] count
//            (W)   bit3 = 1 clears OVF
//   3 CTRL   (R/W) [0] irq_en, [1] flush (write-only, reads 0)
//   4 CYCLES (R)   latency of the last completed operation
//
// Ports:
//   wb_clk_i, wb_rst_ni                 clock, asynchronous active-low reset
//   wbs_cyc_i .. wbs_dat_o              Wishbone slave (single-cycle ack)
//   gcd_req_val/rdy/msg                 request to the GCD unit, msg = {B,A}
//   gcd_resp_val/rdy/msg                result from the GCD unit
//   irq_o                               registered level interrupt
// ---------------------------------------------------------------------------
module gcd_wb_ctrl #(
    parameter int unsigned W         = 16,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    input  logic           wbs_cyc_i,
    input  logic           wbs_stb_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    output logic           gcd_req_val,
    input  logic           gcd_req_rdy,
    output logic [2*W-1:0] gcd_req_msg,
    input  logic           gcd_resp_val,
    output logic           gcd_resp_rdy,
    input  logic [W-1:0]   gcd_resp_msg,
    output logic           irq_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] IDX_CMD    = 3'd0;
    localparam logic [2:0] IDX_RESULT = 3'd1;
    localparam logic [2:0] IDX_STATUS = 3'd2;
    localparam logic [2:0] IDX_CTRL   = 3'd3;
    localparam logic [2:0] IDX_CYCLES = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic       hit, wr_hit, rd_hit;
    logic [2:0] idx;

    assign idx    = wbs_adr_i[4:2];
    // The !ack term keeps a strobe that is still held during the ack cycle
    // from being decoded as a second access.
    assign hit    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
                  & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign wr_hit = hit & wbs_we_i;
    assign rd_hit = hit & ~wbs_we_i;

    // Byte selects and the byte offset carry no meaning: every access is a
    // full word.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    // ------------------------------------------------------------------
    // Register-side events
    // ------------------------------------------------------------------
    logic cmd_wr, cmd_accept, cmd_drop, status_wr, ctrl_wr, result_rd;
    logic push, pop, flush;

    logic [3:0]    count_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [W-1:0]  fifo_mem [DEPTH];
    logic          full, nonempty;

    logic          ovf_q, irq_en_q;
    logic [31:0]   cnt_q, cycles_q;
    logic [2*W-1:0] msg_q;

    assign full       = (count_q == 4'(DEPTH));
    assign nonempty   = (count_q != 4'd0);

    assign cmd_wr     = wr_hit & (idx == IDX_CMD);
    assign cmd_accept = cmd_wr & (state_q == S_IDLE);
    assign cmd_drop   = cmd_wr & (state_q != S_IDLE);
    assign status_wr  = wr_hit & (idx == IDX_STATUS);
    assign ctrl_wr    = wr_hit & (idx == IDX_CTRL);
    assign result_rd  = rd_hit & (idx == IDX_RESULT);

    assign pop        = result_rd & nonempty;
    assign push       = (state_q == S_WAIT) & gcd_resp_val & ~full;
    assign flush      = ctrl_wr & wbs_dat_i[1];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of block ordering.
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        gcd_req_val  = 1'b0;
        gcd_resp_rdy = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                gcd_req_val = 1'b1;
                if (gcd_req_rdy) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A full FIFO stalls the response rather than dropping it.
                gcd_resp_rdy = ~full;
                if (push) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gcd_req_msg = msg_q;

    // ------------------------------------------------------------------
    // Control/status registers and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            msg_q    <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            cnt_q    <= '0;
            cycles_q <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (cmd_accept) msg_q <= {wbs_dat_i[16 +: W], wbs_dat_i[0 +: W]};

            if (cmd_drop)                       ovf_q <= 1'b1;
            else if (status_wr && wbs_dat_i[3]) ovf_q <= 1'b0;

            if (ctrl_wr) irq_en_q <= wbs_dat_i[0];

            // The counter reads 1 in the first ISSUE cycle, so the value
            // present during the response handshake already includes it.
            if (cmd_accept)                                cnt_q <= 32'd1;
            else if (state_q != S_IDLE && cnt_q != '1)     cnt_q <= cnt_q + 32'd1;

            if (push) cycles_q <= cnt_q;

            irq_o <= irq_en_q & (nonempty | ovf_q);
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            // Flush wins over a same-cycle push; that result is discarded.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers and count, so resetting the data would only cost logic.
    always_ff @(posedge wb_clk_i) begin
        if (push && !flush) fifo_mem[wr_ptr_q] <= gcd_resp_msg;
    end

    // ------------------------------------------------------------------
    // Read mux and Wishbone response
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (idx)
            IDX_RESULT: if (nonempty) rd_data = 32'(fifo_mem[rd_ptr_q]);
            IDX_STATUS: rd_data = {24'd0, count_q, ovf_q, full, nonempty,
                                   (state_q != S_IDLE)};
            IDX_CTRL:   rd_data = {31'd0, irq_en_q};
            IDX_CYCLES: rd_data = cycles_q;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= rd_hit ? rd_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_gcd_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gcd_wb_ctrl
//
// Directed bench for gcd_wb_ctrl. Bench inputs change on the falling edge,
// DUT outputs are sampled on the falling edge. A small background GCD
// responder answers requests; its readiness is steered by rdy_en/resp_en.
// Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_gcd_wb_ctrl;

    localparam int unsigned W         = 16;
    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] BASE_ADDR = 32'h3000_0000;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_ni = 1'b0;
    logic           wbs_cyc_i = 1'b0;
    logic           wbs_stb_i = 1'b0;
    logic           wbs_we_i = 1'b0;
    logic [3:0]     wbs_sel_i = 4'hF;
    logic [31:0]    wbs_adr_i = '0;
    logic [31:0]    wbs_dat_i = '0;
    logic           wbs_ack_o;
    logic [31:0]    wbs_dat_o;
    logic           gcd_req_val;
    logic           gcd_req_rdy = 1'b0;
    logic [2*W-1:0] gcd_req_msg;
    logic           gcd_resp_val = 1'b0;
    logic           gcd_resp_rdy;
    logic [W-1:0]   gcd_resp_msg = '0;
    logic           irq_o;

    int checks = 0;
    int errors = 0;

    gcd_wb_ctrl #(.W(W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_ni    (wb_rst_ni),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .gcd_req_val  (gcd_req_val),
        .gcd_req_rdy  (gcd_req_rdy),
        .gcd_req_msg  (gcd_req_msg),
        .gcd_resp_val (gcd_resp_val),
        .gcd_resp_rdy (gcd_resp_rdy),
        .gcd_resp_msg (gcd_resp_msg),
        .irq_o        (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // ------------------------------------------------------------------
    // Background GCD responder (acts 1 time unit after each falling edge)
    // ------------------------------------------------------------------
    bit          rdy_en  = 1'b1;
    bit          resp_en = 1'b1;
    bit          req_fire = 1'b0, resp_fire = 1'b0, have_op = 1'b0;
    logic [15:0] op_a = '0, op_b = '0;

    function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always begin
        @(negedge wb_clk_i);
        #1;
        if (!wb_rst_ni) begin
            gcd_req_rdy  = 1'b0;
            gcd_resp_val = 1'b0;
            gcd_resp_msg = '0;
            req_fire     = 1'b0;
            resp_fire    = 1'b0;
            have_op      = 1'b0;
        end else begin
            gcd_req_rdy = rdy_en;
            if (resp_fire) begin
                gcd_resp_val = 1'b0;
                resp_fire    = 1'b0;
            end
            if (req_fire) begin
                have_op  = 1'b1;
                req_fire = 1'b0;
            end
            if (have_op && resp_en && !gcd_resp_val) begin
                gcd_resp_val = 1'b1;
                gcd_resp_msg = gcd16(op_a, op_b);
                have_op      = 1'b0;
            end
            if (gcd_req_val && gcd_req_rdy) begin
                req_fire = 1'b1;
                op_a     = gcd_req_msg[15:0];
                op_b     = gcd_req_msg[31:16];
            end
            if (gcd_resp_val && gcd_resp_rdy) resp_fire = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Wishbone access (stimulus only; results left in the variables below)
    // ------------------------------------------------------------------
    logic [31:0] rdata;
    logic [31:0] msg_at_ack;
    logic        ack_first, ack_ok, req_before, req_at_ack, irq_at_ack;

    task automatic wb_access(input logic w, input logic [31:0] addr, input logic [31:0] data);
        @(negedge wb_clk_i);
        req_before = gcd_req_val;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        wbs_we_i   = w;
        wbs_adr_i  = addr;
        wbs_dat_i  = data;
        @(negedge wb_clk_i);
        ack_first  = wbs_ack_o;
        rdata      = wbs_dat_o;
        req_at_ack = gcd_req_val;
        msg_at_ack = gcd_req_msg;
        irq_at_ack = irq_o;
        wbs_cyc_i  = 1'b0;
        wbs_stb_i  = 1'b0;
        wbs_we_i   = 1'b0;
        wbs_adr_i  = '0;
        wbs_dat_i  = '0;
        @(negedge wb_clk_i);
        ack_ok = ack_first && !wbs_ack_o;
    endtask

    task automatic wb_write(input int idx, input logic [31:0] data);
        wb_access(1'b1, BASE_ADDR + 32'(idx * 4), data);
    endtask

    task automatic wb_read(input int idx);
        wb_access(1'b0, BASE_ADDR + 32'(idx * 4), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        #12;
        checks++; if ({wbs_ack_o, gcd_req_val, gcd_resp_rdy, irq_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl_outputs: got %b expected 0000",
                               {wbs_ack_o, gcd_req_val, gcd_resp_rdy, irq_o}); end
        checks++; if (wbs_dat_o !== 32'd0 || gcd_req_msg !== 32'd0) begin
            errors++; $display("FAIL reset_data_outputs: got dat %h msg %h expected 0 0",
                               wbs_dat_o, gcd_req_msg); end
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        wb_read(2);
        checks++; if (rdata !== 32'h0 || !ack_ok) begin
            errors++; $display("FAIL reset_status: got %h ack_ok %b expected 0 1", rdata, ack_ok); end
        wb_read(4);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_cycles: got %h expected 0", rdata); end
        wb_read(3);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 0", rdata); end
    endtask

    task automatic test_basic_op();
        wb_write(0, 32'h000F_0006);
        checks++; if (req_before !== 1'b0 || req_at_ack !== 1'b1) begin
            errors++; $display("FAIL t1_req_timing: got before %b at_ack %b expected 0 1",
                               req_before, req_at_ack); end
        checks++; if (msg_at_ack !== 32'h000F_0006) begin
            errors++; $display("FAIL t1_req_msg: got %h expected 000f0006", msg_at_ack); end
        repeat (3) @(negedge wb_clk_i);
        wb_read(1);
        checks++; if (rdata !== 32'h3) begin
            errors++; $display("FAIL t1_result: got %h expected 3", rdata); end
        wb_read(2);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL t1_status: got %h expected 0", rdata); end
        wb_read(4);
        checks++; if (rdata !== 32'd2) begin
            errors++; $display("FAIL t1_cycles: got %0d expected 2", rdata); end
    endtask

    task automatic test_req_stall_ovf();
        int bad;
        rdy_en = 1'b0;
        @(negedge wb_clk_i);
        wb_write(0, 32'h0015_000E);            // B=21, A=14 -> 7
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            if (gcd_req_val !== 1'b1 || gcd_req_msg !== 32'h0015_000E) bad++;
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL t2_req_stable: got %0d unstable cycles expected 0", bad); end
        wb_write(0, 32'h0003_0009);            // dropped while busy
        checks++; if (gcd_req_msg !== 32'h0015_000E || gcd_req_val !== 1'b1) begin
            errors++; $display("FAIL t2_drop_msg: got val %b msg %h expected 1 0015000e",
                               gcd_req_val, gcd_req_msg); end
        wb_read(2);
        checks++; if (rdata !== 32'h09) begin
            errors++; $display("FAIL t2_status_busy_ovf: got %h expected 09", rdata); end
        checks++; if (irq_o !== 1'b0) begin
            errors++; $display("FAIL t2_irq_disabled: got %b expected 0", irq_o); end
        rdy_en = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        wb_read(1);
        checks++; if (rdata !== 32'h7) begin
            errors++; $display("FAIL t2_result: got %h expected 7", rdata); end
        wb_read(2);
        checks++; if (rdata !== 32'h08) begin
            errors++; $display("FAIL t2_status_ovf: got %h expected 08", rdata); end
        wb_write(2, 32'h08);
        wb_read(2);
        checks++; if (rdata !== 32'h00) begin
            errors++; $display("FAIL t2_ovf_w1c: got %h expected 00", rdata); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] cmds [5];
        logic [31:0] exp_res [5];
        cmds = '{32'h0008_000C, 32'h0015_0023, 32'h0005_0011, 32'h004B_0064, 32'h0024_0030};
        exp_res = '{32'd4, 32'd7, 32'd1, 32'd25, 32'd12};
        for (int i = 0; i < 4; i++) begin
            wb_write(0, cmds[i]);
            repeat (3) @(negedge wb_clk_i);
        end
        wb_write(0, cmds[4]);
        repeat (5) @(negedge wb_clk_i);
        checks++; if (gcd_resp_rdy !== 1'b0 || gcd_resp_val !== 1'b1) begin
            errors++; $display("FAIL t3_stall: got resp_rdy %b resp_val %b expected 0 1",
                               gcd_resp_rdy, gcd_resp_val); end
        wb_read(2);
        checks++; if (rdata !== 32'h47) begin
            errors++; $display("FAIL t3_status_full_busy: got %h expected 47", rdata); end
        wb_read(1);
        checks++; if (rdata !== exp_res[0]) begin
            errors++; $display("FAIL t3_result0: got %h expected %h", rdata, exp_res[0]); end
        repeat (3) @(negedge wb_clk_i);
        wb_read(2);
        checks++; if (rdata !== 32'h46) begin
            errors++; $display("FAIL t3_status_refill: got %h expected 46", rdata); end
        for (int i = 1; i < 5; i++) begin
            wb_read(1);
            checks++; if (rdata !== exp_res[i]) begin
                errors++; $display("FAIL t3_result%0d: got %h expected %h", i, rdata, exp_res[i]); end
        end
        wb_read(2);
        checks++; if (rdata !== 32'h00) begin
            errors++; $display("FAIL t3_status_drained: got %h expected 00", rdata); end
    endtask

    task automatic test_irq();
        bit found;
        wb_write(3, 32'h1);
        checks++; if (irq_o !== 1'b0) begin
            errors++; $display("FAIL t4_irq_idle: got %b expected 0", irq_o); end
        wb_write(0, 32'h0006_0009);            // B=6, A=9 -> 3
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (gcd_resp_val && gcd_resp_rdy) begin
                found = 1'b1;
                break;
            end
            @(negedge wb_clk_i);
        end
        checks++; if (!found) begin
            errors++; $display("FAIL t4_push_timeout: got no response handshake expected one"); end
        @(negedge wb_clk_i);
        checks++; if (irq_o !== 1'b0) begin
            errors++; $display("FAIL t4_irq_early: got %b expected 0", irq_o); end
        @(negedge wb_clk_i);
        checks++; if (irq_o !== 1'b1) begin
            errors++; $display("FAIL t4_irq_rise: got %b expected 1", irq_o); end
        wb_read(1);
        checks++; if (rdata !== 32'h3 || irq_at_ack !== 1'b1) begin
            errors++; $display("FAIL t4_result_irq_at_ack: got %h %b expected 3 1", rdata, irq_at_ack); end
        checks++; if (irq_o !== 1'b0) begin
            errors++; $display("FAIL t4_irq_fall: got %b expected 0", irq_o); end
        wb_write(3, 32'h0);
    endtask

    task automatic test_empty_unmapped_flush();
        wb_read(1);
        checks++; if (rdata !== 32'h0 || !ack_ok) begin
            errors++; $display("FAIL t5_empty_result: got %h ack_ok %b expected 0 1", rdata, ack_ok); end
        wb_read(2);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL t5_empty_count: got %h expected 0", rdata); end
        wb_read(7);
        checks++; if (rdata !== 32'h0 || !ack_ok) begin
            errors++; $display("FAIL t5_unmapped: got %h ack_ok %b expected 0 1", rdata, ack_ok); end
        wb_access(1'b0, BASE_ADDR + 32'h100 + 32'h10, 32'd0);
        checks++; if (ack_first !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL t5_no_decode: got ack %b data %h expected 0 0", ack_first, rdata); end
        wb_write(0, 32'h0008_000C);
        repeat (3) @(negedge wb_clk_i);
        wb_write(0, 32'h0015_0023);
        repeat (3) @(negedge wb_clk_i);
        wb_read(2);
        checks++; if (rdata !== 32'h22) begin
            errors++; $display("FAIL t5_two_queued: got %h expected 22", rdata); end
        wb_write(3, 32'h3);
        wb_read(3);
        checks++; if (rdata !== 32'h1) begin
            errors++; $display("FAIL t5_ctrl_readback: got %h expected 1", rdata); end
        wb_read(2);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL t5_flush: got %h expected 0", rdata); end
        wb_write(3, 32'h0);
    endtask

    task automatic test_reset_mid_op();
        wb_write(3, 32'h1);
        resp_en = 1'b0;
        wb_write(0, 32'h0004_0008);
        repeat (2) @(negedge wb_clk_i);
        wb_write(0, 32'h0001_0001);            // dropped: sets OVF
        repeat (2) @(negedge wb_clk_i);
        checks++; if (irq_o !== 1'b1 || gcd_resp_rdy !== 1'b1 || gcd_req_msg !== 32'h0004_0008) begin
            errors++; $display("FAIL t6_pre_reset: got irq %b resp_rdy %b msg %h expected 1 1 00040008",
                               irq_o, gcd_resp_rdy, gcd_req_msg); end
        #2;
        wb_rst_ni = 1'b0;
        #1;
        checks++; if ({wbs_ack_o, gcd_req_val, gcd_resp_rdy, irq_o} !== 4'b0000
                      || wbs_dat_o !== 32'd0 || gcd_req_msg !== 32'd0) begin
            errors++; $display("FAIL t6_async_reset: got ctl %b dat %h msg %h expected 0000 0 0",
                               {wbs_ack_o, gcd_req_val, gcd_resp_rdy, irq_o}, wbs_dat_o, gcd_req_msg); end
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        resp_en   = 1'b1;
        wb_read(2);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL t6_status: got %h expected 0", rdata); end
        wb_read(4);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL t6_cycles: got %h expected 0", rdata); end
        wb_read(3);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL t6_ctrl: got %h expected 0", rdata); end
    endtask

    initial begin
        test_reset();
        test_basic_op();
        test_req_stall_ovf();
        test_fifo_full();
        test_irq();
        test_empty_unmapped_flush();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
